p4_hdr_reg_loader: RTL and testbench

- AXI4-Lite master (initiator) that programs one full header set into the P4 header register block, then optionally reads every word back and compares it.
- Sits between the control plane (or a test sequencer) and the header register block's AXI-Lite slave port.
- One cfg handshake produces 9 sequential single-beat writes, then, when VERIFY=1, 9 sequential reads, then a done/error status pulse.

---
 rtl/p4_hdr_reg_loader.sv | 236 +++++++++++++++++++++++
 tb/tb_p4_hdr_reg_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p4_hdr_reg_loader.sv
// AXI4-Lite master that writes one P4 header set (9 words) into the header
// register block and, optionally, reads every word back and compares it.
module p4_hdr_reg_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter bit          VERIFY    = 1'b1
) (
    input  logic        axil_aclk,
    input  logic        axil_aresetn,

    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [47:0] cfg_smac,
    input  logic [47:0] cfg_dmac,
    input  logic [31:0] cfg_sip,
    input  logic [31:0] cfg_dip,
    input  logic [15:0] cfg_sport,
    input  logic [15:0] cfg_dport,
    input  logic [15:0] cfg_ipsum,

    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [3:0]  err_idx,

    output logic        m_axil_awvalid,
    input  logic        m_axil_awready,
    output logic [31:0] m_axil_awaddr,
    output logic        m_axil_wvalid,
    input  logic        m_axil_wready,
    output logic [31:0] m_axil_wdata,
    output logic [3:0]  m_axil_wstrb,
    input  logic        m_axil_bvalid,
    output logic        m_axil_bready,
    input  logic [1:0]  m_axil_bresp,
    output logic        m_axil_arvalid,
    input  logic        m_axil_arready,
    output logic [31:0] m_axil_araddr,
    input  logic        m_axil_rvalid,
    output logic        m_axil_rready,
    input  logic [31:0] m_axil_rdata,
    input  logic [1:0]  m_axil_rresp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WRESP,
        S_RD,
        S_RDATA,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd8;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [3:0]  err_idx_q, err_idx_d;
    logic        cfg_load;

    logic [47:0] smac_q, dmac_q;
    logic [31:0] sip_q, dip_q;
    logic [15:0] sport_q, dport_q, ipsum_q;

    logic [31:0] word;
    logic [31:0] word_addr;
    logic        aw_ok, w_ok;

    // Captured header set; only meaningful once the FSM has left IDLE.
    always_ff @(posedge axil_aclk) begin
        if (cfg_load) begin
            smac_q  <= cfg_smac;
            dmac_q  <= cfg_dmac;
            sip_q   <= cfg_sip;
            dip_q   <= cfg_dip;
            sport_q <= cfg_sport;
            dport_q <= cfg_dport;
            ipsum_q <= cfg_ipsum;
        end
    end

    always_comb begin
        word = 32'h0;
        case (idx_q)
            4'd0:    word = smac_q[31:0];
            4'd1:    word = {16'h0, smac_q[47:32]};
            4'd2:    word = dmac_q[31:0];
            4'd3:    word = {16'h0, dmac_q[47:32]};
            4'd4:    word = sip_q;
            4'd5:    word = dip_q;
            4'd6:    word = {16'h0, sport_q};
            4'd7:    word = {16'h0, dport_q};
            4'd8:    word = {16'h0, ipsum_q};
            default: word = 32'h0;
        endcase
    end

    assign word_addr     = BASE_ADDR + {26'h0, idx_q, 2'b00};
    assign m_axil_awaddr = word_addr;
    assign m_axil_araddr = word_addr;
    assign m_axil_wdata  = word;
    assign m_axil_wstrb  = 4'hF;
    assign err_code      = err_code_q;
    assign err_idx       = err_idx_q;

    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            err_code_q <= 2'd0;
            err_idx_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            err_code_q <= err_code_d;
            err_idx_q  <= err_idx_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        err_code_d     = err_code_q;
        err_idx_d      = err_idx_q;
        cfg_load       = 1'b0;
        cfg_ready      = 1'b0;
        busy           = (state_q != S_IDLE);
        done           = 1'b0;
        err            = 1'b0;
        m_axil_awvalid = 1'b0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        aw_ok          = 1'b0;
        w_ok           = 1'b0;

        case (state_q)
            S_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    cfg_load   = 1'b1;
                    idx_d      = 4'd0;
                    err_code_d = 2'd0;
                    err_idx_d  = 4'd0;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    state_d    = S_WR;
                end
            end

            // AW and W complete independently; each valid is held until its own handshake.
            S_WR: begin
                m_axil_awvalid = !aw_done_q;
                m_axil_wvalid  = !w_done_q;
                aw_ok          = aw_done_q || m_axil_awready;
                w_ok           = w_done_q || m_axil_wready;
                aw_done_d      = aw_ok;
                w_done_d       = w_ok;
                if (aw_ok && w_ok) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WRESP;
                end
            end

            S_WRESP: begin
                m_axil_bready = 1'b1;
                if (m_axil_bvalid) begin
                    if (m_axil_bresp != 2'b00) begin
                        err_code_d = 2'd1;
                        err_idx_d  = idx_q;
                        state_d    = S_DONE;
                    end else if (idx_q == LAST_IDX) begin
                        if (VERIFY) begin
                            idx_d   = 4'd0;
                            state_d = S_RD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_WR;
                    end
                end
            end

            S_RD: begin
                m_axil_arvalid = 1'b1;
                if (m_axil_arready) begin
                    state_d = S_RDATA;
                end
            end

            S_RDATA: begin
                m_axil_rready = 1'b1;
                if (m_axil_rvalid) begin
                    if (m_axil_rresp != 2'b00) begin
                        err_code_d = 2'd2;
                        err_idx_d  = idx_q;
                        state_d    = S_DONE;
                    end else if (m_axil_rdata != word) begin
                        err_code_d = 2'd3;
                        err_idx_d  = idx_q;
                        state_d    = S_DONE;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_RD;
                    end
                end
            end

            S_DONE: begin
                done    = 1'b1;
                err     = (err_code_q != 2'd0);
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_p4_hdr_reg_loader.sv
// Directed bench for p4_hdr_reg_loader: a VERIFY=1 and a VERIFY=0 instance share
// one configurable AXI-Lite slave model, selected by sel_nv.
module tb_p4_hdr_reg_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel_nv;
    logic        cfg_valid;
    logic [47:0] cfg_smac, cfg_dmac;
    logic [31:0] cfg_sip, cfg_dip;
    logic [15:0] cfg_sport, cfg_dport, cfg_ipsum;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // VERIFY=1 instance signals
    logic        v_cfg_ready, v_busy, v_done, v_err;
    logic [1:0]  v_err_code;
    logic [3:0]  v_err_idx;
    logic        v_awvalid, v_wvalid, v_bready, v_arvalid, v_rready;
    logic [31:0] v_awaddr, v_wdata, v_araddr;
    logic [3:0]  v_wstrb;
    // VERIFY=0 instance signals
    logic        n_cfg_ready, n_busy, n_done, n_err;
    logic [1:0]  n_err_code;
    logic [3:0]  n_err_idx;
    logic        n_awvalid, n_wvalid, n_bready, n_arvalid, n_rready;
    logic [31:0] n_awaddr, n_wdata, n_araddr;
    logic [3:0]  n_wstrb;

    // slave side
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;

    assign s_awvalid = sel_nv ? n_awvalid : v_awvalid;
    assign s_awaddr  = sel_nv ? n_awaddr  : v_awaddr;
    assign s_wvalid  = sel_nv ? n_wvalid  : v_wvalid;
    assign s_wdata   = sel_nv ? n_wdata   : v_wdata;
    assign s_wstrb   = sel_nv ? n_wstrb   : v_wstrb;
    assign s_bready  = sel_nv ? n_bready  : v_bready;
    assign s_arvalid = sel_nv ? n_arvalid : v_arvalid;
    assign s_araddr  = sel_nv ? n_araddr  : v_araddr;
    assign s_rready  = sel_nv ? n_rready  : v_rready;

    logic        o_cfg_ready, o_busy, o_done, o_err;
    logic [1:0]  o_err_code;
    logic [3:0]  o_err_idx;
    assign o_cfg_ready = sel_nv ? n_cfg_ready : v_cfg_ready;
    assign o_busy      = sel_nv ? n_busy      : v_busy;
    assign o_done      = sel_nv ? n_done      : v_done;
    assign o_err       = sel_nv ? n_err       : v_err;
    assign o_err_code  = sel_nv ? n_err_code  : v_err_code;
    assign o_err_idx   = sel_nv ? n_err_idx   : v_err_idx;

    p4_hdr_reg_loader #(.BASE_ADDR(32'h0000_0000), .VERIFY(1'b1)) u_dut (
        .axil_aclk(clk), .axil_aresetn(rst_n),
        .cfg_valid(cfg_valid && !sel_nv), .cfg_ready(v_cfg_ready),
        .cfg_smac(cfg_smac), .cfg_dmac(cfg_dmac), .cfg_sip(cfg_sip), .cfg_dip(cfg_dip),
        .cfg_sport(cfg_sport), .cfg_dport(cfg_dport), .cfg_ipsum(cfg_ipsum),
        .busy(v_busy), .done(v_done), .err(v_err), .err_code(v_err_code), .err_idx(v_err_idx),
        .m_axil_awvalid(v_awvalid), .m_axil_awready(s_awready && !sel_nv), .m_axil_awaddr(v_awaddr),
        .m_axil_wvalid(v_wvalid), .m_axil_wready(s_wready && !sel_nv), .m_axil_wdata(v_wdata),
        .m_axil_wstrb(v_wstrb), .m_axil_bvalid(s_bvalid && !sel_nv), .m_axil_bready(v_bready),
        .m_axil_bresp(s_bresp), .m_axil_arvalid(v_arvalid), .m_axil_arready(s_arready && !sel_nv),
        .m_axil_araddr(v_araddr), .m_axil_rvalid(s_rvalid && !sel_nv), .m_axil_rready(v_rready),
        .m_axil_rdata(s_rdata), .m_axil_rresp(s_rresp)
    );

    p4_hdr_reg_loader #(.BASE_ADDR(32'h0000_0000), .VERIFY(1'b0)) u_dut_nv (
        .axil_aclk(clk), .axil_aresetn(rst_n),
        .cfg_valid(cfg_valid && sel_nv), .cfg_ready(n_cfg_ready),
        .cfg_smac(cfg_smac), .cfg_dmac(cfg_dmac), .cfg_sip(cfg_sip), .cfg_dip(cfg_dip),
        .cfg_sport(cfg_sport), .cfg_dport(cfg_dport), .cfg_ipsum(cfg_ipsum),
        .busy(n_busy), .done(n_done), .err(n_err), .err_code(n_err_code), .err_idx(n_err_idx),
        .m_axil_awvalid(n_awvalid), .m_axil_awready(s_awready && sel_nv), .m_axil_awaddr(n_awaddr),
        .m_axil_wvalid(n_wvalid), .m_axil_wready(s_wready && sel_nv), .m_axil_wdata(n_wdata),
        .m_axil_wstrb(n_wstrb), .m_axil_bvalid(s_bvalid && sel_nv), .m_axil_bready(n_bready),
        .m_axil_bresp(s_bresp), .m_axil_arvalid(n_arvalid), .m_axil_arready(s_arready && sel_nv),
        .m_axil_araddr(n_araddr), .m_axil_rvalid(s_rvalid && sel_nv), .m_axil_rready(n_rready),
        .m_axil_rdata(s_rdata), .m_axil_rresp(s_rresp)
    );

    // ---------------- slave model ----------------
    int          aw_delay = 0;
    int          bad_idx  = -1;
    bit          swap_sport = 1'b0;
    logic [31:0] mem [0:15];
    int          aw_cnt, aw_hs_cnt, w_hs_cnt, ar_hs_cnt, viol_cnt;
    logic        got_aw, got_w, aw_pend, w_pend;
    logic [31:0] addr_l, data_l, last_waddr;
    logic        aw_hs, w_hs;
    logic [31:0] cur_waddr, cur_wdata;
    int          v_inc;

    assign s_awready = s_awvalid && (aw_cnt >= aw_delay);
    assign s_wready  = s_wvalid;
    assign s_arready = s_arvalid;
    assign s_rresp   = 2'b00;
    assign aw_hs     = s_awvalid && s_awready;
    assign w_hs      = s_wvalid && s_wready;
    assign cur_waddr = got_aw ? addr_l : s_awaddr;
    assign cur_wdata = got_w ? data_l : s_wdata;
    assign v_inc = int'(got_w && s_wvalid) + int'(got_aw && s_awvalid)
                 + int'(aw_pend && !s_awvalid) + int'(w_pend && !s_wvalid)
                 + int'(aw_hs && (s_awaddr[1:0] != 2'b00 || s_awaddr > 32'h20))
                 + int'(w_hs && s_wstrb != 4'hF);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_bresp <= 2'b00; s_rdata <= 32'h0;
            got_aw <= 1'b0; got_w <= 1'b0; aw_pend <= 1'b0; w_pend <= 1'b0;
            aw_cnt <= 0; addr_l <= 32'h0; data_l <= 32'h0; last_waddr <= 32'hFFFF_FFFF;
        end else begin
            viol_cnt <= viol_cnt + v_inc;
            aw_pend  <= s_awvalid && !s_awready;
            w_pend   <= s_wvalid && !s_wready;
            aw_cnt   <= (s_awvalid && !s_awready) ? aw_cnt + 1 : 0;
            if (aw_hs) begin addr_l <= s_awaddr; got_aw <= 1'b1; aw_hs_cnt <= aw_hs_cnt + 1; end
            if (w_hs)  begin data_l <= s_wdata;  got_w  <= 1'b1; w_hs_cnt  <= w_hs_cnt + 1;  end
            if (s_bvalid && s_bready) s_bvalid <= 1'b0;
            if ((got_aw || aw_hs) && (got_w || w_hs)) begin
                mem[cur_waddr[5:2]] <= cur_wdata;
                if (swap_sport && cur_waddr[5:2] == 4'd7) mem[6] <= cur_wdata;
                last_waddr <= cur_waddr;
                s_bvalid   <= 1'b1;
                s_bresp    <= (int'(cur_waddr[5:2]) == bad_idx) ? 2'b10 : 2'b00;
                got_aw     <= 1'b0;
                got_w      <= 1'b0;
            end
            if (s_rvalid && s_rready) s_rvalid <= 1'b0;
            if (s_arvalid && s_arready) begin
                s_rvalid  <= 1'b1;
                s_rdata   <= mem[s_araddr[5:2]];
                ar_hs_cnt <= ar_hs_cnt + 1;
            end
        end
    end

    initial begin
        aw_hs_cnt = 0; w_hs_cnt = 0; ar_hs_cnt = 0; viol_cnt = 0;
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    int          rel, faw, aonly, arc;
    logic        e_s;
    logic [1:0]  ec_s;
    logic [3:0]  ei_s;
    int          aw0, w0, ar0, vi0;

    task automatic run_cfg(input logic [47:0] smac, input logic [47:0] dmac,
                           input logic [31:0] sip, input logic [31:0] dip,
                           input logic [15:0] sport, input logic [15:0] dport,
                           input logic [15:0] ipsum);
        int  t0;
        bit  found;
        @(negedge clk);
        check("cfg_ready_idle", {63'h0, o_cfg_ready}, 64'd1);
        aw0 = aw_hs_cnt; w0 = w_hs_cnt; ar0 = ar_hs_cnt; vi0 = viol_cnt;
        cfg_smac = smac; cfg_dmac = dmac; cfg_sip = sip; cfg_dip = dip;
        cfg_sport = sport; cfg_dport = dport; cfg_ipsum = ipsum;
        cfg_valid = 1'b1;
        t0 = cyc;
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_smac = 48'hFFFF_FFFF_FFFF; cfg_sport = 16'hDEAD; cfg_ipsum = 16'h0000;
        rel = -1; faw = -1; aonly = 0; arc = 0; found = 1'b0;
        e_s = 1'b0; ec_s = 2'd0; ei_s = 4'd0;
        for (int i = 0; i < 400 && !found; i++) begin
            cfg_valid = (i >= 2 && i < 5);
            if (s_awvalid && faw < 0) faw = cyc - t0;
            if (s_awvalid && !s_wvalid) aonly++;
            if (s_arvalid) arc++;
            if (o_done) begin
                found = 1'b1; rel = cyc - t0;
                e_s = o_err; ec_s = o_err_code; ei_s = o_err_idx;
            end else begin
                @(negedge clk);
            end
        end
        cfg_valid = 1'b0;
        check("done_seen", {63'h0, found}, 64'd1);
        @(negedge clk);
        check("done_one_cycle", {62'h0, o_done, o_busy}, 64'd0);
    endtask

    logic hit, done_during_rst;

    initial begin
        rst_n = 1'b0; sel_nv = 1'b0; cfg_valid = 1'b0;
        cfg_smac = '0; cfg_dmac = '0; cfg_sip = '0; cfg_dip = '0;
        cfg_sport = '0; cfg_dport = '0; cfg_ipsum = '0;
        repeat (3) @(negedge clk);
        check("rst_ready_busy_done_err", {60'h0, o_cfg_ready, o_busy, o_done, o_err}, 64'h8);
        check("rst_code_idx", {58'h0, o_err_code, o_err_idx}, 64'h0);
        check("rst_valids", {59'h0, v_awvalid, v_wvalid, v_arvalid, v_bready, v_rready}, 64'h0);
        rst_n = 1'b1;

        // zero-wait, VERIFY=1
        run_cfg(48'h0A0B0C0D0E0F, 48'h112233445566, 32'hC0A8_0001, 32'hC0A8_0002,
                16'h0050, 16'h1234, 16'hBEEF);
        check("t1_first_aw", faw, 1);
        check("t1_done_cycle", rel, 37);
        check("t1_err", {61'h0, e_s, ec_s}, 64'h0);
        check("t1_mem0", mem[0], 32'h0C0D_0E0F);
        check("t1_mem1", mem[1], 32'h0000_0A0B);
        check("t1_mem7", mem[7], 32'h0000_1234);
        check("t1_mem8", mem[8], 32'h0000_BEEF);
        check("t1_aw_w_ar", {aw_hs_cnt - aw0, w_hs_cnt - w0, ar_hs_cnt - ar0}, {32'd9, 32'd9, 32'd9} & 64'hFFFF_FFFF_FFFF_FFFF);
        check("t1_ar_cycles", arc, 9);
        check("t1_protocol", viol_cnt - vi0, 0);

        // awready delayed 3 cycles, wready immediate
        aw_delay = 3;
        run_cfg(48'h0A0B0C0D0E0F, 48'h112233445566, 32'hC0A8_0001, 32'hC0A8_0002,
                16'h0050, 16'h1234, 16'hBEEF);
        aw_delay = 0;
        check("t2_aw_only_cycles", aonly, 27);
        check("t2_single_writes", {aw_hs_cnt - aw0, w_hs_cnt - w0}, {32'd9, 32'd9});
        check("t2_protocol", viol_cnt - vi0, 0);
        check("t2_done_cycle", rel, 64);
        check("t2_err", {61'h0, e_s, ec_s}, 64'h0);

        // bad bresp on idx 4
        bad_idx = 4;
        run_cfg(48'h0A0B0C0D0E0F, 48'h112233445566, 32'hC0A8_0001, 32'hC0A8_0002,
                16'h0050, 16'h1234, 16'hBEEF);
        bad_idx = -1;
        check("t3_err_code_idx", {57'h0, e_s, ec_s, ei_s}, {57'h0, 1'b1, 2'd1, 4'd4});
        check("t3_aw_w_ar", {aw_hs_cnt - aw0, w_hs_cnt - w0, ar_hs_cnt - ar0}, {32'd5, 32'd5, 32'd0} & 64'hFFFF_FFFF_FFFF_FFFF);
        check("t3_ar_cycles", arc, 0);
        check("t3_done_cycle", rel, 11);

        // slave stores dport into the sport register
        swap_sport = 1'b1;
        run_cfg(48'h0A0B0C0D0E0F, 48'h112233445566, 32'hC0A8_0001, 32'hC0A8_0002,
                16'h1111, 16'h2222, 16'hBEEF);
        swap_sport = 1'b0;
        check("t4_err_code_idx", {57'h0, e_s, ec_s, ei_s}, {57'h0, 1'b1, 2'd3, 4'd6});
        check("t4_done_cycle", rel, 33);
        @(negedge clk);
        check("t4_code_idx_hold", {58'h0, o_err_code, o_err_idx}, {58'h0, 2'd3, 4'd6});

        // VERIFY=0 instance
        sel_nv = 1'b1;
        run_cfg(48'h0A0B0C0D0E0F, 48'h112233445566, 32'hC0A8_0001, 32'hC0A8_0002,
                16'h0050, 16'h1234, 16'h7777);
        check("t5_done_cycle", rel, 19);
        check("t5_no_ar", {arc, ar_hs_cnt - ar0}, 64'h0);
        check("t5_aw", aw_hs_cnt - aw0, 9);
        check("t5_err", {61'h0, e_s, ec_s}, 64'h0);
        check("t5_mem8", mem[8], 32'h0000_7777);
        sel_nv = 1'b0;

        // reset pulse during WRESP of idx 3
        @(negedge clk);
        cfg_smac = 48'h0A0B0C0D0E0F; cfg_dport = 16'h1234;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (s_bready && s_bvalid && last_waddr == 32'h0000_000C) hit = 1'b1;
            else @(negedge clk);
        end
        check("t6_reach_wresp3", {63'h0, hit}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_valids_dropped", {59'h0, v_awvalid, v_wvalid, v_arvalid, v_bready, v_rready}, 64'h0);
        check("t6_ready_busy", {62'h0, o_cfg_ready, o_busy}, 64'h2);
        done_during_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (o_done) done_during_rst = 1'b1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (o_done) done_during_rst = 1'b1;
        check("t6_no_done", {63'h0, done_during_rst}, 64'd0);
        run_cfg(48'h0A0B0C0D0E0F, 48'h112233445566, 32'hC0A8_0001, 32'hC0A8_0002,
                16'h0050, 16'h1234, 16'hBEEF);
        check("t6_fresh_done_cycle", rel, 37);
        check("t6_fresh_err", {61'h0, e_s, ec_s}, 64'h0);
        check("t6_fresh_aw_ar", {aw_hs_cnt - aw0, ar_hs_cnt - ar0}, {32'd9, 32'd9});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
